uart_tx_queue: RTL and testbench

Byte queue and launch sequencer sitting directly upstream of the UART transmitter. It accepts bytes from the host side in single-cycle writes and buffers them in a DEPTH-entry FIFO. It then drives the transmitter's trigger/data inputs one byte at a time, waiting for each frame to complete before launching the next. The queue decouples bursty producers from the serial line rate.

---
 rtl/uart_tx_queue.sv | 143 ++++++++++++++
 tb/tb_uart_tx_queue.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_queue.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_queue
// Description : Byte FIFO plus launch sequencer feeding a UART transmitter.
//               Host bytes are buffered in a DEPTH-entry circular queue and
//               handed to the transmitter one frame at a time, each launch
//               waiting for the previous frame's tx_done.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_queue #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          tx_trigger,
    output logic [7:0]    tx_din,
    input  logic          tx_busy,
    input  logic          tx_done
);

    localparam logic [AW-1:0] C_PTR_ONE  = AW'(1);
    localparam logic [AW:0]   C_CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   C_CNT_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t        state_q,    state_d;
    logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [AW:0]   count_q,    count_d;
    logic          full_q,     full_d;
    logic          empty_q,    empty_d;
    logic          overflow_q, overflow_d;
    logic          trig_q,     trig_d;
    logic [7:0]    din_q,      din_d;
    logic [7:0]    mem_q [DEPTH];

    logic          w_push;
    logic          w_pop;

    // Accept a byte only when there is room; launch only from IDLE with a
    // byte waiting and the transmitter free.
    always_comb begin
        w_push = wr_en && !full_q;
        w_pop  = (state_q == ST_IDLE) && !empty_q && !tx_busy;
    end

    // Launch sequencer: next state, trigger pulse and held transmit byte.
    always_comb begin
        state_d = state_q;
        trig_d  = 1'b0;
        din_d   = din_q;
        case (state_q)
            ST_IDLE: begin
                if (w_pop) begin
                    state_d = ST_ISSUE;
                    trig_d  = 1'b1;
                    din_d   = mem_q[rd_ptr_q];
                end
            end
            ST_ISSUE: begin
                // tx_done here belongs to no frame of ours and is ignored.
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Queue bookkeeping: pointers, occupancy, flags and dropped-write pulse.
    always_comb begin
        wr_ptr_d   = w_push ? (wr_ptr_q + C_PTR_ONE) : wr_ptr_q;
        rd_ptr_d   = w_pop  ? (rd_ptr_q + C_PTR_ONE) : rd_ptr_q;
        count_d    = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + C_CNT_ONE;
            2'b01:   count_d = count_q - C_CNT_ONE;
            default: count_d = count_q;
        endcase
        full_d     = (count_d == C_CNT_FULL);
        empty_d    = (count_d == '0);
        // A write while full is lost even if a pop frees a slot this cycle.
        overflow_d = wr_en && full_q;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            trig_q     <= 1'b0;
            din_q      <= 8'h00;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            trig_q     <= trig_d;
            din_q      <= din_d;
        end
    end

    // Queue storage; stale contents are harmless because pointers reset.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign full       = full_q;
    assign empty      = empty_q;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign tx_trigger = trig_q;
    assign tx_din     = din_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_queue
// Description : Self-checking bench for uart_tx_queue. A queue-level model
//               predicts every output each cycle; directed scenarios add
//               literal expectations on top.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_queue;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          wr_en   = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          tx_busy = 1'b0;
    logic          tx_done = 1'b0;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          tx_trigger;
    logic [7:0]    tx_din;

    always #5 clk = ~clk;

    uart_tx_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .tx_trigger (tx_trigger),
        .tx_din     (tx_din),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    int  total  = 0;
    int  bad    = 0;
    int  cyc    = 0;
    bit  chk_en = 1'b0;

    // ---------------- behavioural model ----------------
    // mq holds the waiting bytes; m_fl says a frame is launched and not yet
    // finished; m_trig marks the single cycle right after a launch.
    logic [7:0] mq [$];
    logic       m_fl   = 1'b0;
    logic       m_trig = 1'b0;
    logic       m_ovf  = 1'b0;
    logic [7:0] m_din  = 8'h00;

    // Apply one clock edge of queue/transmitter rules to the model.
    always @(posedge clk) begin : model
        bit launch;
        bit accept;
        if (rst) begin
            mq.delete();
            m_fl   <= 1'b0;
            m_trig <= 1'b0;
            m_ovf  <= 1'b0;
            m_din  <= 8'h00;
        end else begin
            launch = !m_fl && (mq.size() != 0) && !tx_busy;
            accept = wr_en && (mq.size() != DEPTH);
            m_ovf  <= wr_en && (mq.size() == DEPTH);
            m_trig <= launch;
            if (launch) begin
                m_din <= mq[0];
                m_fl  <= 1'b1;
            end else if (m_fl && !m_trig && tx_done) begin
                m_fl  <= 1'b0;
            end
            if (launch) void'(mq.pop_front());
            if (accept) mq.push_back(wr_data);
        end
    end

    // ---------------- automatic transmitter ----------------
    bit         auto_tx   = 1'b0;
    int         tx_left   = 0;
    int         last_done = -1;
    logic [7:0] cur_din   = 8'h00;
    logic [7:0] rx [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Advance one cycle, compare every output with the model, then let the
    // transmitter model react (tx_done 20 cycles after each trigger).
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (chk_en) begin
            chk("full",     32'(full),       32'(mq.size() == DEPTH));
            chk("empty",    32'(empty),      32'(mq.size() == 0));
            chk("count",    32'(count),      32'(mq.size()));
            chk("overflow", 32'(overflow),   32'(m_ovf));
            chk("trigger",  32'(tx_trigger), 32'(m_trig));
            chk("tx_din",   32'(tx_din),     32'(m_din));
        end
        if (auto_tx) begin
            tx_done = 1'b0;
            if (tx_trigger) begin
                rx.push_back(tx_din);
                cur_din = tx_din;
                tx_busy = 1'b1;
                tx_left = 20;
                if (last_done >= 0) chk("done_to_trig_gap", 32'(cyc - last_done), 32'd2);
            end else if (tx_left > 0) begin
                chk("din_hold", 32'(tx_din), 32'(cur_din));
                tx_left--;
                if (tx_left == 0) begin
                    tx_done   = 1'b1;
                    tx_busy   = 1'b0;
                    last_done = cyc;
                end
            end
        end
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // Run until k bytes have been transmitted and the last frame is done.
    task automatic wait_idle(input int k);
        int n;
        n = 0;
        while ((rx.size() < k || tx_left > 0 || tx_done) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) chk("drain_timeout", 32'(rx.size()), 32'(k));
    endtask

    int ovf_cnt;

    initial begin
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_full",  32'(full),       32'd0);
        chk("rst_empty", 32'(empty),      32'd1);
        chk("rst_count", 32'(count),      32'd0);
        chk("rst_trig",  32'(tx_trigger), 32'd0);
        chk("rst_din",   32'(tx_din),     32'h00);
        rst = 1'b0;
        repeat (5) tick();

        // ---- single byte: count 1 next cycle, trigger two cycles after write
        write_byte(8'hA5);
        chk("single_count1", 32'(count), 32'd1);
        chk("single_empty0", 32'(empty), 32'd0);
        tick();
        chk("single_trig",   32'(tx_trigger), 32'd1);
        chk("single_din",    32'(tx_din),     32'hA5);
        chk("single_count0", 32'(count),      32'd0);
        tx_busy = 1'b1;
        repeat (5) tick();
        tx_done = 1'b1;
        tx_busy = 1'b0;
        tick();
        tx_done = 1'b0;
        repeat (2) tick();

        // ---- burst of five with the 20-cycle transmitter
        rx.delete();
        last_done = -1;
        auto_tx   = 1'b1;
        for (int i = 1; i <= 5; i++) write_byte(8'(i));
        wait_idle(5);
        chk("burst_len", 32'(rx.size()), 32'd5);
        for (int i = 0; i < 5 && i < rx.size(); i++) chk("burst_order", 32'(rx[i]), 32'(i + 1));
        auto_tx = 1'b0;
        tick();

        // ---- fill, overflow and wrap
        tx_busy = 1'b1;
        ovf_cnt = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h10 + i);
            tick();
            if (overflow) ovf_cnt++;
            if (i == DEPTH - 1) chk("fill_full", 32'(full), 32'd1);
        end
        wr_en = 1'b0;
        tick();
        if (overflow) ovf_cnt++;
        chk("ovf_pulses", 32'(ovf_cnt), 32'd2);
        chk("fill_count", 32'(count),   32'(DEPTH));
        rx.delete();
        last_done = -1;
        tx_busy   = 1'b0;
        auto_tx   = 1'b1;
        wait_idle(DEPTH);
        chk("drain_len", 32'(rx.size()), 32'(DEPTH));
        for (int i = 0; i < DEPTH && i < rx.size(); i++) chk("drain_order", 32'(rx[i]), 32'(8'h10 + i));
        rx.delete();
        last_done = -1;
        for (int i = 0; i < 6; i++) write_byte(8'(8'h30 + i));
        wait_idle(6);
        chk("wrap_len", 32'(rx.size()), 32'd6);
        for (int i = 0; i < 6 && i < rx.size(); i++) chk("wrap_order", 32'(rx[i]), 32'(8'h30 + i));
        auto_tx = 1'b0;
        tick();

        // ---- simultaneous push and pop at count 3
        tx_busy = 1'b1;
        write_byte(8'h41);
        write_byte(8'h42);
        write_byte(8'h43);
        chk("simul_pre_count", 32'(count), 32'd3);
        wr_en   = 1'b1;
        wr_data = 8'h44;
        tx_busy = 1'b0;
        tick();
        wr_en   = 1'b0;
        tx_busy = 1'b1;
        chk("simul_count", 32'(count),      32'd3);
        chk("simul_trig",  32'(tx_trigger), 32'd1);
        chk("simul_din",   32'(tx_din),     32'h41);
        repeat (3) tick();
        tx_done = 1'b1;
        tx_busy = 1'b0;
        tick();
        tx_done = 1'b0;
        rx.delete();
        last_done = -1;
        auto_tx   = 1'b1;
        wait_idle(3);
        chk("simul_len", 32'(rx.size()), 32'd3);
        if (rx.size() == 3) chk("simul_last", 32'(rx[2]), 32'h44);
        auto_tx = 1'b0;
        tick();

        // ---- spurious tx_done in IDLE and in ISSUE
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();
        write_byte(8'h55);
        tick();
        chk("spur_trig", 32'(tx_trigger), 32'd1);
        chk("spur_din",  32'(tx_din),     32'h55);
        tx_done = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h66;
        tick();
        tx_done = 1'b0;
        wr_en   = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("spur_no_trig", 32'(tx_trigger), 32'd0);
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();
        chk("spur_next_trig", 32'(tx_trigger), 32'd1);
        chk("spur_next_din",  32'(tx_din),     32'h66);
        repeat (3) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();

        // ---- reset in the middle of a burst with the transmitter busy
        write_byte(8'h71);
        write_byte(8'h72);
        write_byte(8'h73);
        tx_busy = 1'b1;
        tick();
        rst = 1'b1;
        repeat (3) tick();
        chk("mid_rst_full",  32'(full),       32'd0);
        chk("mid_rst_empty", 32'(empty),      32'd1);
        chk("mid_rst_count", 32'(count),      32'd0);
        chk("mid_rst_ovf",   32'(overflow),   32'd0);
        chk("mid_rst_trig",  32'(tx_trigger), 32'd0);
        chk("mid_rst_din",   32'(tx_din),     32'h00);
        rst = 1'b0;
        write_byte(8'h74);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("busy_no_trig", 32'(tx_trigger), 32'd0);
        end
        tx_busy = 1'b0;
        tick();
        chk("post_rst_trig", 32'(tx_trigger), 32'd1);
        chk("post_rst_din",  32'(tx_din),     32'h74);
        repeat (3) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound in case the stimulus itself stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
